// File: rtl/cpu_types_pkg.sv
// Shared types for the snooping bus controller: word type, RAM handshake states,
// bus FSM states and the snoop timeout counter width.
package cpu_types_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned SNOOP_CNT_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SNOOP      = 3'd1,
    SNOOP_WAIT = 3'd2,
    C2C        = 3'd3,
    FETCH      = 3'd4,
    WB         = 3'd5,
    IFETCH     = 3'd6
  } ccbus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  int unsigned idx;

  // Walk offsets from the far end so the nearest requester wins last.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int unsigned i = N; i > 0; i--) begin
      idx = (32'(ptr) + i - 1) % N;
      if (req[IW'(idx)]) begin
        grant_idx = IW'(idx);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// N-core snooping bus controller: arbitrates coherence, eviction and instruction
// traffic onto a single-ported RAM, with cache-to-cache transfer on snoop hits.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS          = 4,
  parameter int unsigned SNOOP_TIMEOUT = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic  [CPUS-1:0]   iREN,
  input  word_t [CPUS-1:0]   iaddr,
  output logic  [CPUS-1:0]   iwait,
  output word_t [CPUS-1:0]   iload,
  input  logic  [CPUS-1:0]   dREN,
  input  logic  [CPUS-1:0]   dWEN,
  input  word_t [CPUS-1:0]   daddr,
  input  word_t [CPUS-1:0]   dstore,
  output logic  [CPUS-1:0]   dwait,
  output word_t [CPUS-1:0]   dload,
  input  logic  [CPUS-1:0]   cctrans,
  input  logic  [CPUS-1:0]   ccwrite,
  output logic  [CPUS-1:0]   ccwait,
  output logic  [CPUS-1:0]   ccinv,
  output word_t [CPUS-1:0]   ccsnoopaddr,
  input  ramstate_t          ramstate,
  input  word_t              ramload,
  output word_t              ramaddr,
  output word_t              ramstore,
  output logic               ramWEN,
  output logic               ramREN
);

  localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  ccbus_state_t           state, state_nxt;
  logic [IW-1:0]          req, req_nxt;
  logic [IW-1:0]          resp, resp_nxt;
  logic                   rdx, rdx_nxt;
  word_t                  req_addr, req_addr_nxt;
  logic [IW-1:0]          d_ptr, d_ptr_nxt;
  logic [IW-1:0]          i_ptr, i_ptr_nxt;
  logic [SNOOP_CNT_W-1:0] snoop_cnt, snoop_cnt_nxt;

  logic [CPUS-1:0] d_cand;
  logic [IW-1:0]   d_grant, i_grant;
  logic            d_valid, i_valid;
  logic            ram_access, ram_stall;
  logic            resp_found;
  logic [IW-1:0]   resp_idx;

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] g);
    return (32'(g) == CPUS - 1) ? '0 : IW'(32'(g) + 1);
  endfunction

  // Coherence transactions outrank plain evictions for the data arbiter.
  assign d_cand     = (|cctrans) ? cctrans : (dWEN & ~cctrans);
  assign ram_access = (ramstate == ACCESS);
  assign ram_stall  = (ramstate == BUSY) || (ramstate == ERROR);

  rr_arbiter #(.N(CPUS)) u_d_arb (
    .req       (d_cand),
    .ptr       (d_ptr),
    .grant_idx (d_grant),
    .valid     (d_valid)
  );

  rr_arbiter #(.N(CPUS)) u_i_arb (
    .req       (iREN),
    .ptr       (i_ptr),
    .grant_idx (i_grant),
    .valid     (i_valid)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      req       <= '0;
      resp      <= '0;
      rdx       <= 1'b0;
      req_addr  <= '0;
      d_ptr     <= '0;
      i_ptr     <= '0;
      snoop_cnt <= '0;
    end else begin
      state     <= state_nxt;
      req       <= req_nxt;
      resp      <= resp_nxt;
      rdx       <= rdx_nxt;
      req_addr  <= req_addr_nxt;
      d_ptr     <= d_ptr_nxt;
      i_ptr     <= i_ptr_nxt;
      snoop_cnt <= snoop_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    req_nxt       = req;
    resp_nxt      = resp;
    rdx_nxt       = rdx;
    req_addr_nxt  = req_addr;
    d_ptr_nxt     = d_ptr;
    i_ptr_nxt     = i_ptr;
    snoop_cnt_nxt = snoop_cnt;
    iwait         = '1;
    dwait         = '1;
    iload         = '0;
    dload         = '0;
    ccwait        = '0;
    ccinv         = '0;
    ccsnoopaddr   = '0;
    ramaddr       = '0;
    ramstore      = '0;
    ramWEN        = 1'b0;
    ramREN        = 1'b0;
    resp_found    = 1'b0;
    resp_idx      = '0;

    unique case (state)
      IDLE: begin
        if (|cctrans) begin
          req_nxt      = d_grant;
          rdx_nxt      = ccwrite[d_grant];
          req_addr_nxt = daddr[d_grant];
          d_ptr_nxt    = ptr_after(d_grant);
          state_nxt    = SNOOP;
        end else if (d_valid) begin
          req_nxt   = d_grant;
          d_ptr_nxt = ptr_after(d_grant);
          state_nxt = WB;
        end else if (i_valid) begin
          req_nxt   = i_grant;
          i_ptr_nxt = ptr_after(i_grant);
          state_nxt = IFETCH;
        end
      end

      SNOOP: begin
        ccwait = '1;
        for (int unsigned j = 0; j < CPUS; j++) begin
          if (IW'(j) != req) begin
            ccsnoopaddr[j] = req_addr;
            ccinv[j]       = rdx;
          end
        end
        snoop_cnt_nxt = '0;
        state_nxt     = SNOOP_WAIT;
      end

      SNOOP_WAIT: begin
        // Lowest-numbered flushing cache becomes the responder.
        for (int unsigned j = 0; j < CPUS; j++) begin
          if (IW'(j) != req) begin
            ccsnoopaddr[j] = req_addr;
            ccinv[j]       = rdx;
            ccwait[j]      = 1'b1;
            if (dWEN[j] && !resp_found) begin
              resp_found = 1'b1;
              resp_idx   = IW'(j);
            end
          end
        end
        if (resp_found) begin
          resp_nxt  = resp_idx;
          state_nxt = C2C;
        end else if (snoop_cnt == SNOOP_CNT_W'(SNOOP_TIMEOUT - 1)) begin
          state_nxt = FETCH;
        end else begin
          snoop_cnt_nxt = SNOOP_CNT_W'(snoop_cnt + 1'b1);
        end
      end

      C2C: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr[resp];
        ramstore     = dstore[resp];
        dload[req]   = dstore[resp];
        ccwait[resp] = 1'b1;
        if (ram_access) begin
          dwait[req]  = 1'b0;
          dwait[resp] = 1'b0;
        end
        if (!dWEN[resp] && !ram_stall) state_nxt = IDLE;
      end

      FETCH: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[req];
        dload[req] = ramload;
        if (ram_access) dwait[req] = 1'b0;
        if (!dREN[req] && !ram_stall) state_nxt = IDLE;
      end

      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req];
        ramstore = dstore[req];
        if (ram_access) dwait[req] = 1'b0;
        if (!dWEN[req] && !ram_stall) state_nxt = IDLE;
      end

      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[req];
        iload[req] = ramload;
        if (ram_access) begin
          iwait[req] = 1'b0;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: stimulus queues expected handshakes,
// a negedge monitor pops and compares each dwait/iwait drop.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned CPUS = 4;
  localparam word_t       KEY  = 32'hA5A5_0000;

  logic               CLK = 1'b0;
  logic               nRST;
  logic  [CPUS-1:0]   iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  word_t [CPUS-1:0]   iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  ramstate_t          ramstate;
  word_t              ramload, ramaddr, ramstore;
  logic               ramWEN, ramREN;

  logic  ram_ok;
  logic  use_model;
  word_t ram_word;

  typedef struct {
    bit    is_i;
    int    core;
    word_t data;
    word_t addr;
    logic  wen;
    logic  ren;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  coherence_bus_ctrl #(.CPUS(CPUS), .SNOOP_TIMEOUT(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramWEN(ramWEN), .ramREN(ramREN)
  );

  always #5 CLK = ~CLK;

  // RAM model: single-cycle ACCESS unless stalled; read data derived from address.
  assign ramstate = (ramREN || ramWEN) ? (ram_ok ? ACCESS : BUSY) : FREE;
  assign ramload  = use_model ? (ramaddr ^ KEY) : ram_word;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void push(input bit is_i, input int core, input word_t data,
                               input word_t addr, input logic wen, input logic ren);
    exp_t e;
    e.is_i = is_i; e.core = core; e.data = data; e.addr = addr; e.wen = wen; e.ren = ren;
    sb.push_back(e);
  endfunction

  function automatic void mon_pop(input bit is_i, input int c);
    exp_t  e;
    word_t d;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: %s low on core %0d, nothing expected", is_i ? "iwait" : "dwait", c);
      return;
    end
    e = sb.pop_front();
    d = is_i ? iload[c] : dload[c];
    if (e.is_i != is_i || e.core != c || d !== e.data || ramaddr !== e.addr ||
        ramWEN !== e.wen || ramREN !== e.ren) begin
      errors++;
      $display("FAIL sb_handshake: got i=%0d core=%0d data=%h addr=%h wen=%b ren=%b want i=%0d core=%0d data=%h addr=%h wen=%b ren=%b",
               is_i, c, d, ramaddr, ramWEN, ramREN, e.is_i, e.core, e.data, e.addr, e.wen, e.ren);
    end
  endfunction

  // Monitor: every wait drop is a presented response.
  always @(negedge CLK) begin
    if (nRST) begin
      for (int c = 0; c < int'(CPUS); c++) if (!dwait[c]) mon_pop(1'b0, c);
      for (int c = 0; c < int'(CPUS); c++) if (!iwait[c]) mon_pop(1'b1, c);
    end
  end

  task automatic nxt();
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  initial begin
    logic [3:0] m;
    clear_inputs();
    ram_ok = 1'b1; use_model = 1'b0; ram_word = '0;
    nRST = 1'b0;
    repeat (2) nxt();
    chk("rst_dwait",  32'(dwait),  32'hf);
    chk("rst_iwait",  32'(iwait),  32'hf);
    chk("rst_ccwait", 32'(ccwait), 32'h0);
    chk("rst_ram",    {30'd0, ramWEN, ramREN}, 32'h0);
    #1 nRST = 1'b1;
    nxt();

    // Core 2 BusRd 0x100, nobody answers, RAM supplies 0xDEAD.
    #1 ram_word = 32'h0000_DEAD;
    cctrans[2] = 1'b1; daddr[2] = 32'h100; dREN[2] = 1'b1;
    push(1'b0, 2, 32'h0000_DEAD, 32'h100, 1'b0, 1'b1);
    nxt();
    chk("t1_snoopaddr0", ccsnoopaddr[0], 32'h100);
    chk("t1_snoopaddr1", ccsnoopaddr[1], 32'h100);
    chk("t1_snoopaddr3", ccsnoopaddr[3], 32'h100);
    chk("t1_snoopaddr2", ccsnoopaddr[2], 32'h0);
    chk("t1_ccinv",      32'(ccinv),     32'h0);
    chk("t1_ccwait_all", 32'(ccwait),    32'hf);
    nxt();
    chk("t1_wait1_ccwait", 32'(ccwait), 32'hb);
    chk("t1_wait1_ren",    32'(ramREN), 32'h0);
    nxt();
    chk("t1_wait2_ren",    32'(ramREN), 32'h0);
    nxt();
    chk("t1_fetch_dwait",  32'(dwait),  32'hb);
    #1 cctrans[2] = 1'b0; dREN[2] = 1'b0;
    nxt();
    chk("t1_idle_dwait",   32'(dwait),  32'hf);

    // Core 1 BusRdX 0x200, core 3 supplies 0xBEEF cache-to-cache.
    #1 cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200; dREN[1] = 1'b1;
    push(1'b0, 1, 32'h0000_BEEF, 32'h200, 1'b1, 1'b0);
    push(1'b0, 3, 32'h0,         32'h200, 1'b1, 1'b0);
    nxt();
    chk("t2_ccinv",      32'(ccinv),   32'hd);
    chk("t2_snoopaddr3", ccsnoopaddr[3], 32'h200);
    chk("t2_snoopaddr1", ccsnoopaddr[1], 32'h0);
    #1 dWEN[3] = 1'b1; daddr[3] = 32'h200; dstore[3] = 32'h0000_BEEF;
    nxt();
    chk("t2_wait_ccwait", 32'(ccwait), 32'hd);
    nxt();
    chk("t2_c2c_dwait",    32'(dwait),  32'h5);
    chk("t2_c2c_ramstore", ramstore,    32'h0000_BEEF);
    chk("t2_c2c_ccwait",   32'(ccwait), 32'h8);
    #1 clear_inputs();
    nxt();
    chk("t2_idle_dwait", 32'(dwait), 32'hf);
    chk("t2_idle_ccinv", 32'(ccinv), 32'h0);

    // All cores fetch instructions: served 0,1,2,3, one drop each.
    #1 use_model = 1'b1;
    for (int c = 0; c < 4; c++) begin
      iREN[c]  = 1'b1;
      iaddr[c] = 32'h1000 + 32'(4 * c);
      push(1'b1, c, (32'h1000 + 32'(4 * c)) ^ KEY, 32'h1000 + 32'(4 * c), 1'b0, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      nxt();
      m = 4'b1111 ^ (4'b0001 << k);
      chk($sformatf("t4_iwait_core%0d", k), 32'(iwait), 32'(m));
      #1 iREN[k] = 1'b0;
      nxt();
      chk($sformatf("t4_idle_after%0d", k), 32'(iwait), 32'hf);
    end

    // Core 0 eviction with core 1 ifetch pending: write-back wins.
    #1 dWEN[0] = 1'b1; daddr[0] = 32'h300; dstore[0] = 32'h0000_1234;
    iREN[1] = 1'b1; iaddr[1] = 32'h40;
    push(1'b0, 0, 32'h0, 32'h300, 1'b1, 1'b0);
    push(1'b1, 1, 32'h40 ^ KEY, 32'h40, 1'b0, 1'b1);
    nxt();
    chk("t5_wb_dwait",    32'(dwait), 32'he);
    chk("t5_wb_iwait",    32'(iwait), 32'hf);
    chk("t5_wb_ramstore", ramstore,   32'h0000_1234);
    #1 dWEN[0] = 1'b0;
    nxt();
    chk("t5_idle_iwait", 32'(iwait), 32'hf);
    nxt();
    chk("t5_ifetch_iwait", 32'(iwait), 32'hd);
    #1 iREN[1] = 1'b0;
    nxt();

    // Cores 0 and 3 collide with d_ptr at 1: core 3 first, then core 0.
    #1 cctrans[0] = 1'b1; cctrans[3] = 1'b1; dREN[0] = 1'b1; dREN[3] = 1'b1;
    daddr[0] = 32'h400; daddr[3] = 32'h500;
    push(1'b0, 3, 32'h500 ^ KEY, 32'h500, 1'b0, 1'b1);
    push(1'b0, 0, 32'h400 ^ KEY, 32'h400, 1'b0, 1'b1);
    nxt();
    chk("t3_snoop3_addr0", ccsnoopaddr[0], 32'h500);
    chk("t3_snoop3_ccwait", 32'(ccwait), 32'hf);
    nxt();
    chk("t3_wait3_ccwait", 32'(ccwait), 32'h7);
    nxt();
    nxt();
    chk("t3_fetch3_dwait", 32'(dwait), 32'h7);
    #1 cctrans[3] = 1'b0; dREN[3] = 1'b0;
    nxt();
    nxt();
    chk("t3_snoop0_addr3", ccsnoopaddr[3], 32'h400);
    repeat (3) nxt();
    chk("t3_fetch0_dwait", 32'(dwait), 32'he);
    #1 clear_inputs();
    nxt();
    chk("t3_d_ptr", 32'(dut.d_ptr), 32'h1);

    // Reset while in a stalled cache-to-cache transfer.
    #1 ram_ok = 1'b0;
    cctrans[2] = 1'b1; ccwrite[2] = 1'b1; daddr[2] = 32'h600; dREN[2] = 1'b1;
    nxt();
    #1 dWEN[0] = 1'b1; daddr[0] = 32'h600; dstore[0] = 32'h0000_7777;
    nxt();
    nxt();
    chk("t6_c2c_wen",    32'(ramWEN),  32'h1);
    chk("t6_c2c_dwait",  32'(dwait),   32'hf);
    chk("t6_c2c_dload2", dload[2],     32'h0000_7777);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_wen",    32'(ramWEN),  32'h0);
    chk("t6_rst_ccwait", 32'(ccwait),  32'h0);
    chk("t6_rst_dload2", dload[2],     32'h0);
    chk("t6_rst_ramaddr", ramaddr,     32'h0);
    clear_inputs();
    ram_ok = 1'b1;
    nxt();
    #1 nRST = 1'b1;
    cctrans[0] = 1'b1; cctrans[3] = 1'b1; dREN[0] = 1'b1; dREN[3] = 1'b1;
    daddr[0] = 32'h700; daddr[3] = 32'h800;
    push(1'b0, 0, 32'h700 ^ KEY, 32'h700, 1'b0, 1'b1);
    nxt();
    chk("t6_regrant_addr3", ccsnoopaddr[3], 32'h700);
    chk("t6_regrant_addr0", ccsnoopaddr[0], 32'h0);
    repeat (3) nxt();
    chk("t6_fetch_dwait", 32'(dwait), 32'he);
    #1 clear_inputs();
    nxt();
    chk("t6_idle_dwait", 32'(dwait), 32'hf);

    nxt();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

N-core snooping bus controller sitting between the per-core I/D caches and the single-ported RAM. It is the parametrised successor of the two-core memory controller. It arbitrates coherence transactions (BusRd/BusRdX) and plain evictions round-robin across `CPUS` cores. It broadcasts snoops and invalidations to every non-requesting cache, performs cache-to-cache transfer with simultaneous RAM writeback, and falls back to a RAM fetch when no cache responds within a bounded window. Instruction fetches are served, also round-robin, only when no data work is pending.

## Interface
Parameters:
- `CPUS`, 4: number of cores/cache pairs (2..8)
- `SNOOP_TIMEOUT`, 2: cycles waited for a snoop response before fetching from RAM (1..7)

Ports (`word_t` = 32 bits; per-core vectors indexed by core id):
- `CLK` in 1: clock; all state on rising edge
- `nRST` in 1: asynchronous, active-low reset
- `iREN` in CPUS: icache read request
- `iaddr` in CPUS×32: icache address
- `iwait` out CPUS: icache wait; low one cycle = iload valid
- `iload` out CPUS×32: instruction data
- `dREN`, `dWEN` in CPUS: dcache read / write strobes
- `daddr`, `dstore` in CPUS×32: dcache address / write data
- `dwait` out CPUS: dcache wait; low one cycle = word accepted/returned
- `dload` out CPUS×32: data to dcache
- `cctrans`, `ccwrite` in CPUS: coherence transaction; `ccwrite`=1 → BusRdX, 0 → BusRd
- `ccwait` out CPUS: hold cache snoop FSM / block new transactions
- `ccinv` out CPUS: invalidate snooped line
- `ccsnoopaddr` out CPUS×32: snoop address
- `ramstate` in 2: `ramstate_t` {FREE, BUSY, ACCESS, ERROR}
- `ramload` in 32: RAM read data
- `ramaddr`, `ramstore` out 32: RAM address / write data
- `ramWEN`, `ramREN` out 1: RAM strobes

## Operation
- Registers: `state`, `req` (granted core), `resp` (responder), `rdx`, `req_addr`, `d_ptr` / `i_ptr` (round-robin pointers), `snoop_cnt`.
- Default outputs in every state: `iwait`/`dwait` all 1, `ccwait`/`ccinv` 0, `ccsnoopaddr` 0, `ramWEN`/`ramREN` 0, `ramaddr`/`ramstore` 0, `dload`/`iload` 0.
- IDLE, priority order:
  - (1) any `cctrans` → grant by round-robin from `d_ptr`; latch `req`, `rdx=ccwrite[req]`, `req_addr=daddr[req]`; go SNOOP.
  - (2) any `dWEN & ~cctrans` → grant round-robin from `d_ptr`; go WB.
  - (3) any `iREN` → grant round-robin from `i_ptr`; go IFETCH.
  - On a grant, the matching pointer becomes `(grant+1) mod CPUS`.
- SNOOP (1 cycle): for all j≠req, `ccsnoopaddr[j]=req_addr`, `ccinv[j]=rdx`. `ccwait` = all ones. Clear `snoop_cnt`. Go SNOOP_WAIT.
- SNOOP_WAIT: snoop address/inv held, `ccwait[j]=1` for j≠req.
  - If any `dWEN[j]` with j≠req: latch `resp` = lowest such j; go C2C.
  - Else if `snoop_cnt==SNOOP_TIMEOUT-1`: go FETCH.
  - Else increment `snoop_cnt`.
- C2C: `ramWEN=1`, `ramaddr=daddr[resp]`, `ramstore=dstore[resp]`, `dload[req]=dstore[resp]`, `ccwait[resp]=1`. On `ramstate==ACCESS`, `dwait[req]` and `dwait[resp]` go 0. Stay while `dWEN[resp]` (multi-word block). Go IDLE when `dWEN[resp]` is 0.
- FETCH: `ramREN=1`, `ramaddr=daddr[req]`, `dload[req]=ramload`; on ACCESS `dwait[req]=0`. Stay while `dREN[req]`; go IDLE when it drops.
- WB: `ramWEN=1`, `ramaddr=daddr[req]`, `ramstore=dstore[req]`; on ACCESS `dwait[req]=0`. Go IDLE when `dWEN[req]` drops.
- IFETCH: `ramREN=1`, `ramaddr=iaddr[req]`, `iload[req]=ramload`; on ACCESS `iwait[req]=0`, then go IDLE.
- `ramstate` BUSY or ERROR: waits stay high, state holds; ERROR never releases a wait.
- `dWEN` from a core that is not `req` or `resp` outside IDLE is ignored; that core's flush is stalled by `dwait`.

## Timing
- Reset (async): `state=IDLE`, pointers 0, all registers 0, outputs at defaults.
- Grant decision is made in IDLE; the bus action begins the next cycle.
- Minimum coherence miss with no responder: IDLE, SNOOP, then `SNOOP_TIMEOUT` SNOOP_WAIT cycles, then FETCH.
- `dwait` low is combinational on ACCESS: exactly one cycle per word.
- Simultaneous `cctrans` from several cores: exactly one grant; the others see `ccwait=1` until they win.

## Structure
- `ccbus_state_t` enum and the `SNOOP_CNT_W` constant go in `cpu_types_pkg`.
- Sub-module `rr_arbiter` (parameter `N`; inputs `req`, `ptr`; outputs `grant_idx`, `valid`), instantiated twice (data, instruction).

## Test plan
- CPUS=4, core 2 BusRd 0x100, no responder, RAM returns 0xDEAD → ccsnoopaddr[0,1,3]=0x100, ccinv=0, FETCH after 2 wait cycles, dload[2]=0xDEAD.
- Core 1 BusRdX 0x200, core 3 responds dWEN with 0xBEEF next cycle → ccinv[0,2,3]=1, dload[1]=0xBEEF, ramaddr=0x200, ramWEN=1, dwait[1]=dwait[3]=0 on ACCESS.
- cctrans from cores 0 and 3 together, `d_ptr=1` → core 3 served first, then core 0; `d_ptr` ends at 1.
- iREN on all cores with no data traffic → served in order 0,1,2,3; each `iwait` drops exactly once.
- Plain eviction core 0 (dWEN, no cctrans) while core 1 iREN → WB first, IFETCH after.
- nRST asserted in C2C → outputs return to defaults immediately; next request is granted from core 0.
